dac_wave_gen: RTL
=================

Name: dac_wave_gen

Overview:
Upstream sample source for the 12-bit SPI DAC driver. It generates a periodic waveform from a phase accumulator at a programmable sample rate. Each sample is scaled by an amplitude and shifted by an offset with saturation. Finished samples go to the DAC stage over a valid/ready handshake, and the presented value is held stable for the whole SPI transfer.

Parameters:
PHASE_W, 24, phase accumulator width; legal range 12..32; waveform uses phase[PHASE_W-1 -: 12].
RATE_DIV, 1200, clk12MHz cycles per sample tick (default gives 10 kHz); must be >= 4.

Ports:
clk12MHz  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
enable  input  1  1 = run sample-rate divider and phase accumulator
wave_sel  input  2  0 saw, 1 triangle, 2 square, 3 midscale constant
phase_step  input  PHASE_W  phase increment per tick (frequency word)
amplitude  input  12  gain code; gain = (amplitude+1)/4096
offset  input  12  added after scaling, saturating
clr_overrun  input  1  synchronous clear of overrun flag
sample  output  12  sample presented to DAC stage
sample_valid  output  1  sample holds an unconsumed value
sample_ready  input  1  DAC stage idle and accepting
overrun  output  1  sticky: a sample was dropped
debug_state  output  2  FSM state encoding

Behaviour:
- Reset (rst==0 at an edge): phase=0, divider=0, FSM=IDLE, sample=12'h000, sample_valid=0, overrun=0. Reset overrides everything, including mid-pipeline and mid-handshake. Any pending sample is discarded.
- Divider: while enable=1 it counts 0..RATE_DIV-1 and wraps. A tick occurs in the cycle the count equals RATE_DIV-1. While enable=0 the divider holds at 0 and phase holds. In-flight pipeline work and a pending valid sample still complete.
- On tick: p = phase[PHASE_W-1 -: 12] (pre-increment value) is captured, and phase <= phase + phase_step modulo 2^PHASE_W. The first sample after reset uses phase 0.
- FSM states:
  - IDLE(0): goes to RAW on tick.
  - RAW(1): raw register loaded from p per wave_sel. Always goes to SCALE.
  - SCALE(2): result computed and output logic evaluated. Always goes to IDLE.
  - State 3 is unused and recovers to IDLE.
- Latency: sample_valid is first seen high two clock edges after the tick cycle.
- Waveform computation (raw, 12 bits):
  - saw: raw = p.
  - triangle: p[11]=0 gives {p[10:0],0}; p[11]=1 gives {~p[10:0],0}.
  - square: raw = p[11] ? 12'hFFF : 12'h000.
  - const: raw = 12'h800.
- Scaling: prod = raw * (amplitude+1), with a 13-bit multiplier and 25-bit product. scaled = prod[23:12]. sum = scaled + offset (13 bits). result = sum>4095 ? 12'hFFF : sum[11:0].
- Handshake: a transfer occurs on an edge where sample_valid && sample_ready. The value of sample must not change while sample_valid=1 and no transfer has occurred.
- Leaving SCALE:
  - If sample_valid=0, or a transfer occurs in the same cycle: sample <= result and sample_valid <= 1.
  - Else the result is discarded, sample and sample_valid are unchanged, and overrun <= 1.
- With no new result, a transfer clears sample_valid on that edge.
- Overrun: cleared by clr_overrun=1 unless a set occurs in the same cycle; set wins.
- Configuration inputs are sampled only at tick (wave_sel, phase_step) and in RAW/SCALE (amplitude, offset). Mid-flight changes affect only the stage that samples them.

Test Plan:
1. Saw ramp: PHASE_W=16, RATE_DIV=4, step=16'h1000, amp=FFF, off=0, ready=1 -> samples 000,100,200,...,F00 then wrap to 000; one sample per 4 cycles; valid rises 2 edges after each tick.
2. Triangle: PHASE_W=12, step=12'h400 -> samples 000,800,FFE,7FE, repeating.
3. Scaling and saturation: const wave, amp=7FF, off=0 -> 400. Square at p[11]=1, amp=FFF, off=010 -> FFF saturated.
4. Backpressure: hold ready=0 across two ticks -> first sample held stable with valid=1, second discarded, overrun=1. Raise ready -> transfer, valid=0. Pulse clr_overrun -> overrun=0.
5. Simultaneous transfer and new result in the same edge -> new sample loaded, valid stays 1, no overrun.
6. Pull rst low mid-SCALE with valid=1 -> next edge: valid=0, sample=000, FSM IDLE, phase=0. Next sample after reset comes from phase 0.

Source files
------------

// File: rtl/dac_wave_gen.sv
// Sample source for the SPI DAC: phase-accumulator waveform, gain/offset with
// saturation, and a held output register behind a valid/ready handshake.
module dac_wave_gen #(
   parameter int PHASE_W  = 24,
   parameter int RATE_DIV = 1200
) (
   input  logic               clk12MHz,
   input  logic               rst,
   input  logic               enable,
   input  logic [1:0]         wave_sel,
   input  logic [PHASE_W-1:0] phase_step,
   input  logic [11:0]        amplitude,
   input  logic [11:0]        offset,
   input  logic               clr_overrun,
   output logic [11:0]        sample,
   output logic               sample_valid,
   input  logic               sample_ready,
   output logic               overrun,
   output logic [1:0]         debug_state
);
   localparam int DIV_W = $clog2(RATE_DIV);

   typedef enum logic [1:0] {IDLE = 2'd0, RAW = 2'd1, SCALE = 2'd2, SPARE = 2'd3} state_t;

   state_t             state, state_nxt;
   logic [DIV_W-1:0]   div_cnt;
   logic [PHASE_W-1:0] phase;
   logic [11:0]        p_cap, raw, raw_nxt, scaled, result;
   logic [1:0]         ws_cap;
   logic [12:0]        gain, sum;
   logic [24:0]        prod;
   logic               tick, xfer, leave_scale;

   assign tick = enable && (div_cnt == DIV_W'(RATE_DIV - 1));

   // Phase and wave select are captured together so the sample reflects the tick moment
   always_ff @(posedge clk12MHz) begin
      if (!rst) begin
         div_cnt <= '0;
         phase   <= '0;
         p_cap   <= '0;
         ws_cap  <= '0;
      end else if (!enable) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
         p_cap   <= phase[PHASE_W-1 -: 12];
         ws_cap  <= wave_sel;
         phase   <= phase + phase_step;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk12MHz) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = tick ? RAW : IDLE;
         RAW:     state_nxt = SCALE;
         SCALE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      raw_nxt = 12'h800;
      case (ws_cap)
         2'd0:    raw_nxt = p_cap;
         2'd1:    raw_nxt = p_cap[11] ? {~p_cap[10:0], 1'b0} : {p_cap[10:0], 1'b0};
         2'd2:    raw_nxt = {12{p_cap[11]}};
         default: raw_nxt = 12'h800;
      endcase
   end

   always_ff @(posedge clk12MHz) begin
      if (!rst)              raw <= '0;
      else if (state == RAW) raw <= raw_nxt;
   end

   assign gain   = {1'b0, amplitude} + 13'd1;
   assign prod   = 25'(raw) * 25'(gain);
   assign scaled = 12'(prod >> 12);
   assign sum    = {1'b0, scaled} + {1'b0, offset};
   assign result = sum[12] ? 12'hFFF : sum[11:0];

   assign xfer        = sample_valid && sample_ready;
   assign leave_scale = (state == SCALE);

   // A held, unconsumed sample is never overwritten; the new result is dropped instead
   always_ff @(posedge clk12MHz) begin
      if (!rst) begin
         sample       <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (leave_scale && (!sample_valid || xfer)) begin
            sample       <= result;
            sample_valid <= 1'b1;
         end else if (xfer) begin
            sample_valid <= 1'b0;
         end
         if (leave_scale && sample_valid && !xfer) overrun <= 1'b1;
         else if (clr_overrun)                     overrun <= 1'b0;
      end
   end

   assign debug_state = state;
endmodule
